// File: rtl/game_pkg.sv
// Shared widths and FSM state encodings for the whack-a-mole game-flow controller.
package game_pkg;

  localparam int unsigned SEC_W   = 6;
  localparam int unsigned ROUND_W = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] StIdle  = 3'd0;
  localparam logic [STATE_W-1:0] StReady = 3'd1;
  localparam logic [STATE_W-1:0] StPlay  = 3'd2;
  localparam logic [STATE_W-1:0] StPause = 3'd3;
  localparam logic [STATE_W-1:0] StOver  = 3'd4;

endpackage

// File: rtl/round_time_calc.sv
// Play time for a round: base time minus a per-round decrement, floored at a minimum.
module round_time_calc
  import game_pkg::*;
#(
  parameter int unsigned ROUND_SECONDS = 30,
  parameter int unsigned ROUND_DEC     = 5,
  parameter int unsigned MIN_SECONDS   = 10
) (
  input  logic [ROUND_W-1:0] round_idx_i,
  output logic [SEC_W-1:0]   rt_o
);

  localparam logic signed [6:0] RoundS = 7'(ROUND_SECONDS);
  localparam logic signed [6:0] MinS   = 7'(MIN_SECONDS);

  logic signed [6:0] dec_s;
  logic signed [6:0] diff_s;

  // Signed width lets an over-large decrement go negative and still hit the floor.
  always_comb begin
    dec_s  = 7'(32'(round_idx_i) * ROUND_DEC);
    diff_s = RoundS - dec_s;
    rt_o   = (diff_s < MinS) ? SEC_W'(MIN_SECONDS) : diff_s[SEC_W-1:0];
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Game-flow sequencer: intro countdown, timed rounds, pause/resume and game over,
// driving the one-second countdown timer and exporting phase flags.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int unsigned READY_SECONDS = 3,
  parameter int unsigned ROUND_SECONDS = 30,
  parameter int unsigned ROUND_DEC     = 5,
  parameter int unsigned MIN_SECONDS   = 10,
  parameter int unsigned NUM_ROUNDS    = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic [SEC_W-1:0]   tmr_count,
  input  logic               tmr_done,
  output logic               tmr_reload,
  output logic               tmr_start,
  output logic               tmr_stop,
  output logic [SEC_W-1:0]   tmr_time,
  output logic [STATE_W-1:0] state,
  output logic [ROUND_W-1:0] round_idx,
  output logic               game_active,
  output logic               show_ready,
  output logic               round_start,
  output logic               game_over
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SEC_W-1:0]   time_q, time_d;
  logic reload_q, reload_d, start_q, start_d, stop_q, stop_d;
  logic round_start_q, round_start_d, game_over_q, game_over_d;
  logic active_q, ready_q, done_q;
  logic done_evt;
  logic [SEC_W-1:0] rt;

  // The count is display-only here; fold it into a sink so the port stays.
  logic unused_count;
  assign unused_count = ^tmr_count;

  assign done_evt = tmr_done & ~done_q;

  round_time_calc #(
    .ROUND_SECONDS(ROUND_SECONDS),
    .ROUND_DEC    (ROUND_DEC),
    .MIN_SECONDS  (MIN_SECONDS)
  ) u_round_time (
    .round_idx_i(round_q),
    .rt_o       (rt)
  );

  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    time_d        = time_q;
    reload_d      = 1'b0;
    start_d       = 1'b0;
    stop_d        = 1'b0;
    round_start_d = 1'b0;
    game_over_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_start) begin
          reload_d = 1'b1;
          time_d   = SEC_W'(READY_SECONDS);
          round_d  = '0;
          state_d  = StReady;
        end
      end
      StReady: begin
        if (done_evt) begin
          reload_d      = 1'b1;
          time_d        = rt;
          round_start_d = 1'b1;
          state_d       = StPlay;
        end
      end
      StPlay: begin
        // A timeout takes precedence over a pause arriving in the same cycle.
        if (done_evt) begin
          if (round_q == ROUND_W'(NUM_ROUNDS - 1)) begin
            game_over_d = 1'b1;
            state_d     = StOver;
          end else begin
            round_d  = round_q + ROUND_W'(1);
            reload_d = 1'b1;
            time_d   = SEC_W'(READY_SECONDS);
            state_d  = StReady;
          end
        end else if (btn_pause) begin
          stop_d  = 1'b1;
          state_d = StPause;
        end
      end
      StPause: begin
        if (btn_pause || btn_start) begin
          start_d = 1'b1;
          state_d = StPlay;
        end
      end
      StOver: begin
        if (btn_start) begin
          round_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        round_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      round_q       <= '0;
      time_q        <= '0;
      reload_q      <= 1'b0;
      start_q       <= 1'b0;
      stop_q        <= 1'b0;
      round_start_q <= 1'b0;
      game_over_q   <= 1'b0;
      active_q      <= 1'b0;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      time_q        <= time_d;
      reload_q      <= reload_d;
      start_q       <= start_d;
      stop_q        <= stop_d;
      round_start_q <= round_start_d;
      game_over_q   <= game_over_d;
      active_q      <= (state_d == StPlay);
      ready_q       <= (state_d == StReady);
      done_q        <= tmr_done;
    end
  end

  assign tmr_reload  = reload_q;
  assign tmr_start   = start_q;
  assign tmr_stop    = stop_q;
  assign tmr_time    = time_q;
  assign state       = state_q;
  assign round_idx   = round_q;
  assign game_active = active_q;
  assign show_ready  = ready_q;
  assign round_start = round_start_q;
  assign game_over   = game_over_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: two instances (default and clamped round times) each
// driving a behavioural countdown timer with a 4-cycle second.
module tb_game_timer_ctrl;

  localparam int StIdleI = 0, StReadyI = 1, StPlayI = 2, StPauseI = 3, StOverI = 4;

  logic clk, reset_n, b_en, btn_start, btn_pause, done_force;
  logic rst_a, rst_b;
  logic [1:0] reload, tstart, tstop, done_lvl, tmr_done, rstart, gover, gactive, sready;
  logic [1:0][5:0] tcount, ttime;
  logic [1:0][2:0] st;
  logic [1:0][1:0] ridx;

  int checks, failures;
  int n_reload[2], n_start[2], n_stop[2], n_rstart[2], n_gover[2];
  int q_a[$];
  int q_b[$];

  assign rst_a = reset_n;
  assign rst_b = reset_n & b_en;
  assign tmr_done = done_lvl | {2{done_force}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  game_timer_ctrl u_dut_a (
    .clk(clk), .reset_n(rst_a), .btn_start(btn_start), .btn_pause(btn_pause),
    .tmr_count(tcount[0]), .tmr_done(tmr_done[0]), .tmr_reload(reload[0]),
    .tmr_start(tstart[0]), .tmr_stop(tstop[0]), .tmr_time(ttime[0]), .state(st[0]),
    .round_idx(ridx[0]), .game_active(gactive[0]), .show_ready(sready[0]),
    .round_start(rstart[0]), .game_over(gover[0])
  );

  game_timer_ctrl #(
    .READY_SECONDS(3), .ROUND_SECONDS(20), .ROUND_DEC(8), .MIN_SECONDS(10), .NUM_ROUNDS(3)
  ) u_dut_b (
    .clk(clk), .reset_n(rst_b), .btn_start(btn_start), .btn_pause(btn_pause),
    .tmr_count(tcount[1]), .tmr_done(tmr_done[1]), .tmr_reload(reload[1]),
    .tmr_start(tstart[1]), .tmr_stop(tstop[1]), .tmr_time(ttime[1]), .state(st[1]),
    .round_idx(ridx[1]), .game_active(gactive[1]), .show_ready(sready[1]),
    .round_start(rstart[1]), .game_over(gover[1])
  );

  // Behavioural one-second timer, one per instance.
  for (genvar g = 0; g < 2; g++) begin : g_tmr
    logic rst_g;
    logic [1:0] sub_q;
    logic run_q;
    assign rst_g = (g == 0) ? rst_a : rst_b;
    always @(posedge clk or negedge rst_g) begin
      if (!rst_g) begin
        tcount[g] <= '0; sub_q <= '0; run_q <= 1'b0; done_lvl[g] <= 1'b0;
      end else if (reload[g]) begin
        tcount[g] <= ttime[g]; sub_q <= '0;
        run_q <= (ttime[g] != 0); done_lvl[g] <= (ttime[g] == 0);
      end else if (tstart[g]) begin
        sub_q <= '0; run_q <= (tcount[g] != 0); done_lvl[g] <= (tcount[g] == 0);
      end else if (tstop[g]) begin
        run_q <= 1'b0;
      end else if (run_q) begin
        if (sub_q == 2'd3) begin
          sub_q <= '0;
          tcount[g] <= tcount[g] - 6'd1;
          if (tcount[g] == 6'd1) begin
            done_lvl[g] <= 1'b1; run_q <= 1'b0;
          end
        end else begin
          sub_q <= sub_q + 2'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: each reload pops the next expected reload time.
  always @(negedge clk) begin
    int e;
    for (int g = 0; g < 2; g++) begin
      if ((g == 0) ? rst_a : rst_b) begin
        if (reload[g]) begin
          e = -1;
          if (g == 0 && q_a.size() > 0) e = q_a.pop_front();
          if (g == 1 && q_b.size() > 0) e = q_b.pop_front();
          check($sformatf("reload_time_%0d", g), int'(ttime[g]), e);
          n_reload[g]++;
        end
        if (reload[g] | tstart[g] | tstop[g])
          check($sformatf("cmd_exclusive_%0d", g), $countones({reload[g], tstart[g], tstop[g]}), 1);
        if (tstart[g]) n_start[g]++;
        if (tstop[g]) n_stop[g]++;
        if (rstart[g]) n_rstart[g]++;
        if (gover[g]) n_gover[g]++;
      end
    end
  end

  task automatic press(input logic s, input logic p);
    btn_start = s;
    btn_pause = p;
    @(negedge clk);
    btn_start = 1'b0;
    btn_pause = 1'b0;
  endtask

  initial begin
    int snap;
    logic prev_done;
    checks = 0; failures = 0;
    reset_n = 1'b0; b_en = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; done_force = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", int'(st[0]), StIdleI);
    check("rst_round", int'(ridx[0]), 0);
    check("rst_time", int'(ttime[0]), 0);
    check("rst_pulses", int'({reload[0], tstart[0], tstop[0], rstart[0], gover[0]}), 0);
    check("rst_flags", int'({gactive[0], sready[0]}), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Full games on both instances.
    q_a = '{3, 30, 3, 25, 3, 20};
    q_b = '{3, 20, 3, 12, 3, 10};
    press(1'b1, 1'b0);
    check("start_reload", int'(reload[0]), 1);
    check("start_time", int'(ttime[0]), 3);
    check("start_state", int'(st[0]), StReadyI);
    check("start_show_ready", int'(sready[0]), 1);
    check("start_no_other", int'({tstart[0], tstop[0], rstart[0], gover[0], gactive[0]}), 0);
    for (int i = 0; i < 3000; i++) begin
      if (st[0] == 3'(StOverI) && st[1] == 3'(StOverI)) break;
      @(negedge clk);
    end
    check("game_a_over", int'(st[0]), StOverI);
    check("game_b_over", int'(st[1]), StOverI);
    @(negedge clk);
    check("round_start_cnt_a", n_rstart[0], 3);
    check("game_over_cnt_a", n_gover[0], 1);
    check("round_start_cnt_b", n_rstart[1], 3);
    check("game_over_cnt_b", n_gover[1], 1);
    check("final_round_a", int'(ridx[0]), 2);
    check("reload_cnt_a", n_reload[0], 6);
    check("reload_cnt_b", n_reload[1], 6);
    repeat (5) @(negedge clk);
    check("over_holds", int'(st[0]), StOverI);
    check("over_flags", int'({gactive[0], sready[0]}), 0);
    b_en = 1'b0;

    // Pause / resume.
    press(1'b1, 1'b0);
    check("over_to_idle", int'(st[0]), StIdleI);
    check("idle_round", int'(ridx[0]), 0);
    q_a.push_back(3); q_a.push_back(30);
    press(1'b1, 1'b0);
    for (int i = 0; i < 500; i++) begin
      if (st[0] == 3'(StPlayI) && tcount[0] == 6'd17) break;
      @(negedge clk);
    end
    check("reach_17", int'(tcount[0]), 17);
    press(1'b0, 1'b1);
    check("pause_stop", int'(tstop[0]), 1);
    check("pause_state", int'(st[0]), StPauseI);
    check("pause_inactive", int'(gactive[0]), 0);
    repeat (50) @(negedge clk);
    check("pause_frozen", int'(tcount[0]), 17);
    check("pause_held", int'(st[0]), StPauseI);
    snap = n_start[0];
    press(1'b0, 1'b1);
    check("resume_start", int'(tstart[0]), 1);
    check("resume_state", int'(st[0]), StPlayI);
    check("resume_active", int'(gactive[0]), 1);
    @(negedge clk);
    check("resume_start_once", int'(tstart[0]), 0);
    press(1'b0, 1'b1);
    check("pause2_state", int'(st[0]), StPauseI);
    press(1'b1, 1'b1);
    check("both_resume_state", int'(st[0]), StPlayI);
    @(negedge clk);
    check("start_pulse_cnt", n_start[0] - snap, 2);

    // Pause coincident with the final-round timeout.
    q_a.push_back(3); q_a.push_back(25); q_a.push_back(3); q_a.push_back(20);
    prev_done = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (ridx[0] == 2'd2 && st[0] == 3'(StPlayI) && tmr_done[0] && !prev_done) break;
      prev_done = tmr_done[0];
      @(negedge clk);
    end
    check("final_done_seen", int'(tmr_done[0]), 1);
    snap = n_stop[0];
    press(1'b0, 1'b1);
    check("coinc_game_over", int'(gover[0]), 1);
    check("coinc_no_stop", int'(tstop[0]), 0);
    check("coinc_state", int'(st[0]), StOverI);
    @(negedge clk);
    check("coinc_stop_cnt", n_stop[0] - snap, 0);
    check("coinc_over_cnt", n_gover[0], 2);

    // Asynchronous reset in the middle of round 1.
    press(1'b1, 1'b0);
    q_a.push_back(3); q_a.push_back(30); q_a.push_back(3); q_a.push_back(25);
    press(1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (ridx[0] == 2'd1 && st[0] == 3'(StPlayI)) break;
      @(negedge clk);
    end
    check("mid_round1", int'(ridx[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_state", int'(st[0]), StIdleI);
    check("async_round", int'(ridx[0]), 0);
    check("async_outputs", int'({reload[0], tstart[0], tstop[0], gactive[0], sready[0]}), 0);
    check("async_time", int'(ttime[0]), 0);
    q_a.delete();
    done_force = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    snap = n_reload[0];
    repeat (10) @(negedge clk);
    check("held_done_idle", int'(st[0]), StIdleI);
    check("held_done_no_reload", n_reload[0] - snap, 0);
    done_force = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
